// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receiver.
// Define SPI_RX_SYNC_EN when the SPI master runs asynchronously to clk.
package spi_pkg;

    localparam int DATA_W_DEF = 16;

`ifdef SPI_RX_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Single-bit conditioning register chain; depth follows SPI_RX_SYNC_EN via spi_pkg.
module spi_sync
    import spi_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset) chain <= '0;
                else       chain <= d;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (reset) chain <= '0;
                else       chain <= {chain[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (mode 0 sampling, MSB first) with a valid/ready word output.
// Build with SPI_RX_SYNC_EN for a 2-flop synchronizer on each SPI input.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_L,
    input  logic              spi_sclk,
    input  logic              spi_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic [4:0]        bit_count
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_HOLD  = HOLD;
    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    logic              cs_s;
    logic              sclk_s;
    logic              data_s;
    logic              sclk_prev;
    logic              sclk_rise;
    logic              armed;
    logic              hold_err_seen;
    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic              word_done;
    logic [DATA_W-1:0] new_word;

    spi_sync u_sync_cs   (.clk(clk), .reset(reset), .d(spi_cs_L), .q(cs_s));
    spi_sync u_sync_sclk (.clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s));
    spi_sync u_sync_data (.clk(clk), .reset(reset), .d(spi_data), .q(data_s));

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign word_done = (state == ST_SHIFT) && !cs_s && sclk_rise && (bit_count == LAST_BIT);
    assign new_word  = {shreg[DATA_W-2:0], data_s};

    // armed only sets once cs is seen high, so a reset inside a frame waits for a fresh cs fall
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bit_count     <= '0;
            sclk_prev     <= 1'b1;
            armed         <= 1'b0;
            hold_err_seen <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            frame_err <= 1'b0;
            if (cs_s) armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!cs_s && armed) begin
                        state         <= ST_SHIFT;
                        bit_count     <= '0;
                        shreg         <= '0;
                        hold_err_seen <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_s) begin
                        state     <= ST_IDLE;
                        frame_err <= (bit_count != 5'd0);
                    end else if (sclk_rise) begin
                        shreg     <= new_word;
                        bit_count <= bit_count + 5'd1;
                        if (bit_count == LAST_BIT) state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cs_s) begin
                        state <= ST_IDLE;
                    end else if (sclk_rise && !hold_err_seen) begin
                        frame_err     <= 1'b1;
                        hold_err_seen <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A completing word may replace a word that is being handed off on the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= new_word;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            overrun <= (overrun & ~ovr_clr) | (word_done & rx_valid & ~rx_ready);
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: hand-computed frames checked through one task.
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs_L;
    logic        spi_sclk;
    logic        spi_data;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;
    logic        ovr_clr;
    logic [4:0]  bit_count;

    int checks   = 0;
    int failures = 0;
    int err_count   = 0;
    int valid_count = 0;
    logic [15:0] words[$];
    int err_base;
    int valid_base;

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset), .spi_cs_L(spi_cs_L), .spi_sclk(spi_sclk),
        .spi_data(spi_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun),
        .ovr_clr(ovr_clr), .bit_count(bit_count)
    );

    // Observe outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (frame_err) err_count++;
        if (rx_valid) valid_count++;
        if (rx_valid && rx_ready) words.push_back(rx_data);
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame();
        spi_cs_L = 1'b0;
        repeat (4) tick();
    endtask

    task automatic end_frame();
        spi_cs_L = 1'b1;
        repeat (8) tick();
    endtask

    // Shifts nbits of word MSB first, then pads with ones up to total edges
    task automatic send_bits(input logic [31:0] word, input int nbits, input int total);
        for (int i = 0; i < total; i++) begin
            spi_data = (i < nbits) ? word[nbits-1-i] : 1'b1;
            repeat (4) tick();
            spi_sclk = 1'b1;
            repeat (4) tick();
            spi_sclk = 1'b0;
        end
        repeat (4) tick();
    endtask

    function automatic logic [15:0] pop_word();
        if (words.size() == 0) return 16'hDEAD;
        return words.pop_front();
    endfunction

    initial begin
        reset    = 1'b1;
        spi_cs_L = 1'b1;
        spi_sclk = 1'b0;
        spi_data = 1'b0;
        rx_ready = 1'b1;
        ovr_clr  = 1'b0;
        repeat (3) tick();
        check_output("reset_rx_valid",  32'(rx_valid),  32'd0);
        check_output("reset_rx_data",   32'(rx_data),   32'd0);
        check_output("reset_bit_count", 32'(bit_count), 32'd0);
        check_output("reset_overrun",   32'(overrun),   32'd0);
        check_output("reset_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        err_base = err_count; valid_base = valid_count;
        start_frame();
        check_output("a5c3_bitcnt_start", 32'(bit_count), 32'd0);
        send_bits(32'hA5C3, 16, 16);
        check_output("a5c3_word",       32'(pop_word()),             32'hA5C3);
        check_output("a5c3_valid_cyc",  32'(valid_count - valid_base), 32'd1);
        check_output("a5c3_bitcnt_end", 32'(bit_count),              32'd16);
        end_frame();
        check_output("a5c3_no_err",     32'(err_count - err_base),   32'd0);

        start_frame();
        send_bits(32'h0001, 16, 16);
        spi_cs_L = 1'b1;
        tick();
        spi_cs_L = 1'b0;
        send_bits(32'h8000, 16, 16);
        end_frame();
        check_output("b2b_count",  32'(words.size()), 32'd2);
        check_output("b2b_first",  32'(pop_word()),   32'h0001);
        check_output("b2b_second", 32'(pop_word()),   32'h8000);

        rx_ready = 1'b0;
        start_frame();
        send_bits(32'h1234, 16, 16);
        end_frame();
        start_frame();
        send_bits(32'h5678, 16, 16);
        end_frame();
        check_output("ovr_rx_data", 32'(rx_data),  32'h1234);
        check_output("ovr_valid",   32'(rx_valid), 32'd1);
        check_output("ovr_set",     32'(overrun),  32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tick();
        check_output("ovr_cleared", 32'(overrun), 32'd0);
        rx_ready = 1'b1;
        repeat (2) tick();
        check_output("ovr_drain_word",  32'(pop_word()), 32'h1234);
        check_output("ovr_drain_valid", 32'(rx_valid),   32'd0);

        err_base = err_count; valid_base = valid_count;
        start_frame();
        send_bits(32'h007F, 7, 7);
        end_frame();
        check_output("abort_err_pulse", 32'(err_count - err_base),     32'd1);
        check_output("abort_no_valid",  32'(valid_count - valid_base), 32'd0);
        start_frame();
        send_bits(32'hFFFF, 16, 16);
        end_frame();
        check_output("abort_next_word", 32'(pop_word()), 32'hFFFF);

        err_base = err_count;
        start_frame();
        send_bits(32'h017D, 9, 9);
        reset = 1'b1;
        repeat (2) tick();
        check_output("midrst_valid",  32'(rx_valid),  32'd0);
        check_output("midrst_data",   32'(rx_data),   32'd0);
        check_output("midrst_bitcnt", 32'(bit_count), 32'd0);
        check_output("midrst_ovr",    32'(overrun),   32'd0);
        reset = 1'b0;
        send_bits(32'h006F, 7, 7);
        end_frame();
        check_output("midrst_tail_ignored", 32'(words.size() + (err_count - err_base)), 32'd0);
        start_frame();
        send_bits(32'h00FF, 16, 16);
        end_frame();
        check_output("midrst_next_word", 32'(pop_word()), 32'h00FF);

        err_base = err_count; valid_base = valid_count;
        start_frame();
        send_bits(32'hCAFE, 16, 18);
        end_frame();
        check_output("long_word",      32'(pop_word()),               32'hCAFE);
        check_output("long_err_pulse", 32'(err_count - err_base),     32'd1);
        check_output("long_valid_cyc", 32'(valid_count - valid_base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the frame length in bits and the rx_data width.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port spi_cs_L, input, 1, active-low chip select from the SPI master.
REQ-005 The block SHALL have port spi_sclk, input, 1, serial clock; data is sampled on its rising edge.
REQ-006 The block SHALL have port spi_data, input, 1, MOSI, MSB first.
REQ-007 The block SHALL have port rx_data, output, DATA_W, the last completed word.
REQ-008 The block SHALL have port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-009 The block SHALL have port rx_ready, input, 1, consumer accepts the word when rx_valid and rx_ready are both high.
REQ-010 The block SHALL have port frame_err, output, 1, one-cycle pulse on an aborted or over-long frame.
REQ-011 The block SHALL have port overrun, output, 1, sticky: a completed word was dropped.
REQ-012 The block SHALL have port ovr_clr, input, 1, clears overrun.
REQ-013 The block SHALL have port bit_count, output, 5, bits received in the current frame (0..DATA_W).

Function
REQ-014 The block SHALL detect an sclk rising edge as the conditioned sclk being high now and low on the previous cycle; all three SPI inputs pass through identical conditioning so they stay aligned.
REQ-015 The FSM SHALL have states IDLE (cs high), SHIFT (cs low, bit_count < DATA_W) and HOLD (DATA_W bits taken, waiting for cs high).
REQ-016 IDLE->SHIFT on conditioned cs low; bit_count SHALL be zeroed on entry.
REQ-017 In SHIFT, each sclk rising edge SHALL shift spi_data into the LSB of the shift register (MSB-first assembly) and increment bit_count.
REQ-018 On the DATA_W-th edge the word SHALL load into rx_data, rx_valid SHALL set on the same clock edge, and the FSM SHALL go to HOLD.
REQ-019 In HOLD, further sclk rising edges SHALL be ignored for data and SHALL pulse frame_err once per frame.
REQ-020 Conditioned cs high in SHIFT with 0 < bit_count < DATA_W SHALL pulse frame_err, discard the partial word and return to IDLE; with bit_count = 0, return to IDLE silently.
REQ-021 A cs-high interval of exactly one clk cycle SHALL be accepted as a frame boundary: the next frame is received completely.
REQ-022 rx_valid SHALL clear on a cycle where rx_valid and rx_ready are high and no new word completes.
REQ-023 If a word completes while rx_valid is high and rx_ready is low, the new word SHALL be dropped, rx_data SHALL keep its value and overrun SHALL set.
REQ-024 If a word completes on the same cycle as a handshake, the new word SHALL load, rx_valid SHALL stay high and no overrun SHALL occur.
REQ-025 overrun SHALL clear on ovr_clr; a simultaneous set and clear SHALL leave it set.
REQ-026 Latency: raw spi_sclk sampled high at edge k SHALL shift data at edge k+2 with SPI_RX_SYNC_EN and at edge k+1 without it.

Reset
REQ-027 While reset is high, the FSM SHALL go to IDLE, rx_data, bit_count and the shift register SHALL go to 0, rx_valid, frame_err and overrun SHALL go to 0, and the edge history SHALL be set so that the first post-reset cycle produces no edge.
REQ-028 A reset mid-frame SHALL discard the partial word; reception resumes at the next cs falling edge.

Configuration
REQ-029 With SPI_RX_SYNC_EN defined, each SPI input SHALL pass through a 2-flop synchronizer (asynchronous master); without it, each input SHALL pass through one register stage (master on clk).

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state enum (IDLE/SHIFT/HOLD), the DATA_W default (16) and the synchronizer depth constant.
REQ-031 The synchronizer SHALL be sub-module spi_sync (1-bit, depth from the package), instantiated three times.

Verification
REQ-032 Frame 16'hA5C3 with rx_ready=1 -> rx_data=16'hA5C3, rx_valid high 1 cycle, frame_err=0, bit_count 0->16.
REQ-033 Back-to-back frames 16'h0001 and 16'h8000 with a 1-cycle cs-high gap -> both words delivered in order.
REQ-034 Two frames 16'h1234 and 16'h5678 with rx_ready=0 -> rx_data=16'h1234, overrun=1; ovr_clr -> overrun=0.
REQ-035 cs raised after 7 bits -> one frame_err pulse, rx_valid stays 0; next full frame 16'hFFFF received correctly.
REQ-036 Reset asserted after bit 9 of frame 16'hBEEF -> all outputs 0; next frame 16'h00FF received correctly.
REQ-037 18 sclk edges within one cs-low window, frame 16'hCAFE -> rx_data=16'hCAFE, exactly one frame_err pulse.
